// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: word stores finish in one cycle, loads and sub-word stores (RMW) take two.
// Stall is raised for exactly one cycle while a read of the array is in flight; Done/Error are combinational.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Datatype,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [1:0] {IDLE, RESP, MERGE} state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rd_word;
    logic [31:0]        merged;
    logic [31:0]        lane_ext;
    logic [31:0]        wr_data;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [IDX_W-1:0]   idx;
    logic               is_idle;
    logic               req;
    logic               err;
    logic               rd_issue;
    logic               wr_en;
    logic               unused_addr;

    assign idx         = Address[IDX_W+1:2];
    assign unused_addr = ^Address[31:IDX_W+2];
    assign is_idle     = (state == IDLE);
    assign req         = MemRead | MemWrite;
    assign err         = (MemRead && MemWrite)
                       || (Datatype == 2'b00 && Address[1:0] != 2'b00)
                       || (Datatype == 2'b01 && Address[0]);

    // Loads and sub-word stores both need the old word, so both issue an array read.
    assign rd_issue = !Rst && is_idle && req && !err && (MemRead || Datatype != 2'b00);
    assign wr_en    = !Rst && ((is_idle && MemWrite && !err && Datatype == 2'b00)
                               || state == MERGE);
    assign wr_data  = (state == MERGE) ? merged : WriteData;

    assign Stall = rd_issue;
    assign Done  = !Rst && ((is_idle && req && (err || (MemWrite && Datatype == 2'b00)))
                            || state == RESP || state == MERGE);
    assign Error = !Rst && is_idle && req && err;

    always_comb begin
        byte_sel = rd_word[{Address[1:0], 3'b000} +: 8];
        half_sel = Address[1] ? rd_word[31:16] : rd_word[15:0];
        case (Datatype)
            2'b00:   lane_ext = rd_word;
            2'b01:   lane_ext = {{16{half_sel[15]}}, half_sel};
            2'b10:   lane_ext = {{24{byte_sel[7]}}, byte_sel};
            default: lane_ext = {24'd0, byte_sel};
        endcase
    end

    always_comb begin
        merged = rd_word;
        if (Datatype == 2'b01)
            merged[{Address[1], 4'b0000} +: 16] = WriteData[15:0];
        else
            merged[{Address[1:0], 3'b000} +: 8] = WriteData[7:0];
    end

    // Array contents survive reset; only the control path is cleared.
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[idx] <= wr_data;
        if (rd_issue)
            rd_word <= mem[idx];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            ReadData <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_issue)
                        state <= MemRead ? RESP : MERGE;
                end
                RESP: begin
                    ReadData <= lane_ext;
                    state    <= IDLE;
                end
                MERGE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a byte-addressed reference memory predicts each response; a monitor checks every Done.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  datatype;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          err;
        int          stalls;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [4096];
    logic [31:0] cur_rd;

    always #5 clk = ~clk;

    data_memory_responder dut (
        .Clk      (clk),
        .Rst      (rst),
        .Address  (address),
        .WriteData(write_data),
        .MemRead  (mem_read),
        .MemWrite (mem_write),
        .Datatype (datatype),
        .ReadData (read_data),
        .Stall    (stall),
        .Done     (done),
        .Error    (error)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: memory as 4096 bytes (addresses wrap at 4 KiB), little-endian.
    task automatic model_req(input bit rd, input bit wr, input logic [1:0] dt,
                             input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
        int a;
        logic [31:0] v;
        a = int'(addr % 4096);
        e.err = (rd && wr) || (dt == 2'd0 && a % 4 != 0) || (dt == 2'd1 && a % 2 != 0);
        e.stalls = 0;
        if (!e.err && rd) begin
            e.stalls = 1;
            case (dt)
                2'd0: v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
                2'd1: v = 32'($signed({mb[a+1], mb[a]}));
                2'd2: v = 32'($signed(mb[a]));
                default: v = {24'd0, mb[a]};
            endcase
            cur_rd = v;
        end else if (!e.err && wr) begin
            if (dt == 2'd0) begin
                for (int i = 0; i < 4; i++) mb[a+i] = wd[8*i +: 8];
            end else if (dt == 2'd1) begin
                e.stalls = 1;
                mb[a] = wd[7:0];
                mb[a+1] = wd[15:8];
            end else begin
                e.stalls = 1;
                mb[a] = wd[7:0];
            end
        end
        e.rdata = cur_rd;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the access.
    task automatic do_req(input bit rd, input bit wr, input logic [1:0] dt,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        bit ok;
        model_req(rd, wr, dt, addr, wd, e);
        q.push_back(e);
        mem_read = rd;
        mem_write = wr;
        datatype = dt;
        address = addr;
        write_data = wd;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL stall_timeout: stall still 1, expected release within 8 cycles");
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic idle_cycle();
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: stall cycles, Error and the following ReadData for every Done.
    initial begin
        int          stall_cnt;
        bit          pend;
        logic [31:0] pend_val;
        exp_t        e;
        stall_cnt = 0;
        pend = 1'b0;
        pend_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("read_data", read_data, pend_val);
                    pend = 1'b0;
                end
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("error", 32'(error), 32'(e.err));
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                        pend = 1'b1;
                        pend_val = e.rdata;
                    end
                    stall_cnt = 0;
                end else if (stall) begin
                    stall_cnt++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        address = '0;
        write_data = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        datatype = 2'd0;
        cur_rd = '0;
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;

        @(posedge clk);
        @(negedge clk);
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Word store then load
        do_req(0, 1, 2'd0, 32'h10, 32'hDEADBEEF);
        do_req(1, 0, 2'd0, 32'h10, 32'h0);
        @(negedge clk);
        chk("lw_0x10", read_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Initialise the 64-byte working window
        for (int w = 0; w < 16; w++) do_req(0, 1, 2'd0, 32'(w * 4), $urandom);

        // Sub-word RMW and signed/unsigned byte loads
        do_req(0, 1, 2'd0, 32'h20, 32'h11223344);
        do_req(0, 1, 2'd2, 32'h21, 32'hFFFFFFAB);
        do_req(1, 0, 2'd0, 32'h20, 32'h0);
        do_req(1, 0, 2'd2, 32'h21, 32'h0);
        do_req(1, 0, 2'd3, 32'h21, 32'h0);

        // Halfword store and loads
        do_req(0, 1, 2'd0, 32'h20, 32'h11223344);
        do_req(0, 1, 2'd1, 32'h22, 32'h00008001);
        do_req(1, 0, 2'd1, 32'h22, 32'h0);
        do_req(1, 0, 2'd0, 32'h20, 32'h0);
        @(negedge clk);
        chk("lw_0x20_after_sh", read_data, 32'h80013344);
        @(posedge clk);
        #1;

        // Error requests
        do_req(1, 0, 2'd0, 32'h13, 32'h0);
        do_req(1, 1, 2'd0, 32'h20, 32'h55555555);
        do_req(1, 0, 2'd1, 32'h21, 32'h0);
        do_req(1, 0, 2'd0, 32'h20, 32'h0);

        // Reset during the merge cycle of a byte store
        do_req(0, 1, 2'd0, 32'h30, 32'h0);
        mem_write = 1'b1;
        datatype = 2'd2;
        address = 32'h30;
        write_data = 32'hFF;
        @(negedge clk);
        chk("rmw_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_write = 1'b0;
        cur_rd = '0;
        @(negedge clk);
        chk("rst_mid_read_data", read_data, 32'd0);
        @(posedge clk);
        #1;
        do_req(1, 0, 2'd0, 32'h30, 32'h0);

        // Address wrap, back-to-back
        do_req(0, 1, 2'd0, 32'h1000, 32'hCAFE0001);
        do_req(1, 0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wrap_lw", read_data, 32'hCAFE0001);
        @(posedge clk);
        #1;

        // Random traffic over the window with random high address bits
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0]  dt;
            logic [31:0] addr;
            r = $urandom_range(0, 9);
            dt = 2'($urandom_range(0, 3));
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                if (dt == 2'd0) addr[1:0] = 2'b00;
                else if (dt == 2'd1) addr[0] = 1'b0;
            end
            if (r < 4)       do_req(1, 0, dt, addr, $urandom);
            else if (r < 8)  do_req(0, 1, dt, addr, $urandom);
            else if (r == 8) do_req(1, 1, dt, addr, $urandom);
            else             idle_cycle();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the MEM-stage data-memory interface of the 5-stage MIPS datapath.
- Accepts load/store requests from the pipeline's MEM stage: Address, store data, MemRead/MemWrite and a 2-bit Datatype.
- Serves them from a single-port, word-wide, synchronous-read memory array.
- Sub-word stores are done as read-modify-write, and the block holds the pipeline with a Stall output while a multi-cycle access is in flight.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- IDX_W, 10: log2(DEPTH_WORDS); word index = Address[IDX_W+1:2].

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Address  input  32  byte address from MEM stage (ALU result).
- WriteData  input  32  store data (rt); sub-word data taken from the low bits.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- Datatype  input  2  00 word, 01 halfword signed, 10 byte signed, 11 byte unsigned.
- ReadData  output  32  load result, registered, sign/zero-extended.
- Stall  output  1  combinational; pipeline must hold MEM-stage request and all upstream registers while high.
- Done  output  1  combinational; the access completes this cycle.
- Error  output  1  combinational; valid with Done; misaligned or conflicting request.

Behaviour:
- Reset: state IDLE, ReadData=0, Stall=0, Done=0, Error=0. Array contents are not cleared.
- Rst asserted mid-operation aborts the access: a pending RMW write is not committed and the state returns to IDLE.
- Byte lanes are little-endian within the word:
  - Byte k = bits [8k+7:8k], with k = Address[1:0].
  - Half at Address[1]=0 is bits [15:0]; at Address[1]=1 it is bits [31:16].
- Error condition, evaluated in IDLE:
  - MemRead and MemWrite both high; or
  - Datatype=00 with Address[1:0]!=0; or
  - Datatype=01 with Address[0]!=0.
- On an error request in IDLE: Done=1, Error=1, Stall=0. No array write occurs, ReadData is unchanged, and the state stays IDLE.
- Requests are sampled only in IDLE; when MemRead=MemWrite=0 in IDLE, all outputs except ReadData are 0.
- FSM states: IDLE, RESP, MERGE.
- Load (MemRead=1, no error):
  - Cycle N in IDLE: array read issued, Stall=1, Done=0, next state RESP.
  - Cycle N+1 in RESP: ReadData is loaded at the end of N+1 with the extracted, extended lane; Done=1, Stall=0, next state IDLE.
  - ReadData is visible from N+2 and holds until the next load completes.
  - Extension: Datatype 01 and 10 sign-extend; 11 zero-extends; 00 passes the word.
- Word store (MemWrite=1, Datatype=00, no error): completes in IDLE in cycle N. The array word is written at the end of N, Done=1, Stall=0, and the state stays IDLE.
- Sub-word store (MemWrite=1, Datatype!=00, no error):
  - Cycle N in IDLE: array read issued, Stall=1, next state MERGE.
  - Cycle N+1 in MERGE: the old word is merged with WriteData[7:0] or [15:0] in the addressed lane and written at the end of N+1; Done=1, Stall=0, next state IDLE.
  - Datatype 10 and 11 store identically.
- Address bits above IDX_W+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Requester contract: Address, WriteData, MemRead, MemWrite and Datatype stay stable while Stall=1.
- RESP and MERGE never accept a new request, so the request presented in a Done cycle is not re-issued.
- Back-to-back: a request presented in the cycle immediately after a Done cycle is accepted in IDLE, giving at most one stall cycle per access.
- Read-after-write: a load from a word written in the previous cycle returns the new data, because the array write commits before the read edge.

Test Plan:
- Reset, word store then load:
  - Stimulus: Rst for 2 cycles, then SW Address=0x10, WriteData=0xDEADBEEF; next cycle LW Address=0x10.
  - Required: store Done=1 with Stall=0 in the same cycle; load Stall=1 for 1 cycle, then Done=1; ReadData=0xDEADBEEF afterwards.
- Sub-word RMW and signed loads:
  - Stimulus: word 0x20 preset to 0x11223344; SB Address=0x21, WriteData=0xFFFFFFAB; then LB 0x21 and LBU 0x21.
  - Required: SB gives Stall=1 for one cycle; word becomes 0x1122AB44; LB returns 0xFFFFFFAB; LBU returns 0x000000AB.
- Halfword store and loads:
  - Stimulus: SH Address=0x22, WriteData=0x00008001 onto word 0x11223344; then LH 0x22, then LW 0x20.
  - Required: LH returns 0xFFFF8001; LW returns 0x80013344.
- Error cases:
  - LW Address=0x13 → Done=1, Error=1, Stall=0, ReadData unchanged.
  - MemRead=MemWrite=1 → Error=1, no array change.
  - LH Address=0x21 → Error=1.
- Reset mid-RMW:
  - Stimulus: assert Rst during the MERGE cycle of SB Address=0x30, WriteData=0xFF, with word 0x30 = 0x00000000.
  - Required: word 0x30 stays 0x00000000; outputs return to reset values; the next LW 0x30 returns 0.
- Wrap and back-to-back:
  - Stimulus: SW Address=0x1000 (DEPTH_WORDS=1024), WriteData=0xCAFE0001, immediately followed by LW Address=0x0.
  - Required: LW returns 0xCAFE0001 after exactly 1 stall cycle; no request is lost or duplicated.
